// File: rtl/cpu_usm_v1.sv
// ---------------------------------------------------------------------------
// cpu_usm_v1 -- single-cycle RV32I integer core.
//
// Fetches, executes and retires one instruction per rising clk edge. Both
// memories are external with combinational reads; the data-memory wrapper
// does byte/half lane steering and load extension.
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   asynchronous active-high reset, PC <= RESET_PC
//   instr      in   instruction word at PC
//   data_in    in   load data, already sized/extended per SizeLoad
//   PC         out  registered program counter
//   data_out   out  store data (rs2, unshifted)
//   ALU_result out  ALU output, also the data-memory address
//   MemWrite   out  00 none, 01 SB, 10 SH, 11 SW
//   SizeLoad   out  load funct3, 3'b010 when not a load
//   ResultSrc  out  1 = write-back from data_in
//
// Build option: define CPU_USM_RF_CLEAR_EN to have reset clear x1..x31.
// Without it the register file is not reset.
// ---------------------------------------------------------------------------
module cpu_usm_v1 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] data_in,
    output logic [31:0] PC,
    output logic [31:0] data_out,
    output logic [31:0] ALU_result,
    output logic [1:0]  MemWrite,
    output logic [2:0]  SizeLoad,
    output logic        ResultSrc
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, pc_plus4;
    logic [31:0] alu_b, op_res, alu_res, wb_data;
    logic        br_taken, br_legal, rf_we;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // x0 is never written, so it is forced to zero on the read side
    assign rs1_v    = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_v    = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    // Shared OP / OP-IMM datapath. instr[30] selects SUB only for register
    // ops (for ADDI it is an immediate bit) but selects SRA/SRAI for both.
    always_comb begin
        alu_b  = (opcode == OPC_OP) ? rs2_v : imm_i;
        op_res = 32'd0;
        case (funct3)
            3'b000: op_res = (opcode == OPC_OP && instr[30]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'b001: op_res = rs1_v << alu_b[4:0];
            3'b010: op_res = {31'd0, $signed(rs1_v) < $signed(alu_b)};
            3'b011: op_res = {31'd0, rs1_v < alu_b};
            3'b100: op_res = rs1_v ^ alu_b;
            3'b101: op_res = instr[30] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'b110: op_res = rs1_v | alu_b;
            default: op_res = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        br_legal = 1'b1;
        case (funct3)
            3'b000: br_taken = (rs1_v == rs2_v);
            3'b001: br_taken = (rs1_v != rs2_v);
            3'b100: br_taken = ($signed(rs1_v) <  $signed(rs2_v));
            3'b101: br_taken = ($signed(rs1_v) >= $signed(rs2_v));
            3'b110: br_taken = (rs1_v <  rs2_v);
            3'b111: br_taken = (rs1_v >= rs2_v);
            default: br_legal = 1'b0;
        endcase
    end

    // Main decode; the defaults are the NOP behaviour for anything unsupported.
    always_comb begin
        alu_res   = 32'd0;
        pc_d      = pc_plus4;
        rf_we     = 1'b0;
        wb_data   = 32'd0;
        MemWrite  = 2'b00;
        SizeLoad  = 3'b010;
        ResultSrc = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_res = imm_u;
                rf_we   = 1'b1;
                wb_data = alu_res;
            end
            OPC_AUIPC: begin
                alu_res = pc_q + imm_u;
                rf_we   = 1'b1;
                wb_data = alu_res;
            end
            OPC_JAL: begin
                alu_res = pc_q + imm_j;
                pc_d    = alu_res;
                rf_we   = 1'b1;
                wb_data = pc_plus4;
            end
            OPC_JALR: begin
                alu_res = (rs1_v + imm_i) & ~32'd1;
                pc_d    = alu_res;
                rf_we   = 1'b1;
                wb_data = pc_plus4;
            end
            OPC_BRANCH: begin
                if (br_legal) begin
                    alu_res = rs1_v - rs2_v;
                    if (br_taken) pc_d = pc_q + imm_b;
                end
            end
            OPC_LOAD: begin
                // only LB/LH/LW/LBU/LHU are legal widths
                if (funct3 != 3'b011 && funct3[2:1] != 2'b11) begin
                    alu_res   = rs1_v + imm_i;
                    SizeLoad  = funct3;
                    ResultSrc = 1'b1;
                    rf_we     = 1'b1;
                    wb_data   = data_in;
                end
            end
            OPC_STORE: begin
                if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
                    alu_res  = rs1_v + imm_s;
                    // funct3 00/01/10 maps onto strobe code 01/10/11
                    MemWrite = funct3[1:0] + 2'd1;
                end
            end
            OPC_OPIMM, OPC_OP: begin
                alu_res = op_res;
                rf_we   = 1'b1;
                wb_data = alu_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

`ifdef CPU_USM_RF_CLEAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (rf_we && rd != 5'd0) begin
            rf_q[rd] <= wb_data;
        end
    end
`else
    // No reset on the storage; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && rf_we && rd != 5'd0) rf_q[rd] <= wb_data;
    end
`endif

    assign PC         = pc_q;
    assign data_out   = rs2_v;
    assign ALU_result = alu_res;
endmodule

// File: tb/tb_cpu_usm_v1.sv
module tb_cpu_usm_v1;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, data_in;
    logic [31:0] PC, data_out, ALU_result;
    logic [1:0]  MemWrite;
    logic [2:0]  SizeLoad;
    logic        ResultSrc;

    cpu_usm_v1 #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .instr(instr), .data_in(data_in),
        .PC(PC), .data_out(data_out), .ALU_result(ALU_result),
        .MemWrite(MemWrite), .SizeLoad(SizeLoad), .ResultSrc(ResultSrc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] din;
        logic [31:0] alu;
        logic        chk_dout;
        logic [31:0] dout;
        logic [1:0]  mw;
        logic [2:0]  sl;
        logic        rs;
        logic [31:0] pc_nxt;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] d, input logic [31:0] a,
                                input logic cd, input logic [31:0] dout, input logic [1:0] mw,
                                input logic [2:0] sl, input logic rs, input logic [31:0] pn);
        vec_t v;
        v.instr = i; v.din = d; v.alu = a; v.chk_dout = cd; v.dout = dout;
        v.mw = mw; v.sl = sl; v.rs = rs; v.pc_nxt = pn;
        return v;
    endfunction

    // plain ALU/jump/branch instruction: no memory activity
    function automatic vec_t mkp(input logic [31:0] i, input logic [31:0] a, input logic [31:0] pn);
        return mk(i, 32'd0, a, 1'b0, 32'd0, 2'b00, 3'b010, 1'b0, pn);
    endfunction

    initial begin
        logic [31:0] x1_exp;
        // "addi x0, xN, 0" is used as a probe: ALU_result shows xN, nothing is written
        vecs.push_back(mkp(32'h0000_0000, 32'h0000_0000, 32'd4));          // PC0  illegal zero word
        vecs.push_back(mkp(32'h0020_0093, 32'd2, 32'd8));                  // PC4  addi x1,x0,2
        vecs.push_back(mk (32'h0010_A023, 0, 32'd2, 1, 32'd2, 2'b11, 3'b010, 0, 32'd12)); // sw x1,0(x1)
        vecs.push_back(mk (32'h0040_0103, 32'hFFFF_FF80, 32'd4, 0, 0, 2'b00, 3'b000, 1, 32'd16)); // lb x2,4(x0)
        vecs.push_back(mkp(32'h0001_0013, 32'hFFFF_FF80, 32'd20));         // probe x2
        vecs.push_back(mkp(32'h0020_0193, 32'd2, 32'd24));                 // addi x3,x0,2
        vecs.push_back(mkp(32'hFE30_8CE3, 32'd0, 32'd16));                 // beq x1,x3,-8 taken
        vecs.push_back(mkp(32'hFE30_9CE3, 32'd0, 32'd20));                 // bne x1,x3,-8 not taken
        vecs.push_back(mkp(32'h0100_02EF, 32'd36, 32'd36));                // jal x5,+16
        vecs.push_back(mkp(32'h0002_8013, 32'd24, 32'd40));                // probe x5
        vecs.push_back(mkp(32'h0030_8367, 32'd4, 32'd4));                  // jalr x6,3(x1)
        vecs.push_back(mkp(32'h0003_0013, 32'd44, 32'd8));                 // probe x6
        vecs.push_back(mkp(32'h0050_0013, 32'd5, 32'd12));                 // addi x0,x0,5
        vecs.push_back(mkp(32'h0000_0013, 32'd0, 32'd16));                 // probe x0
        vecs.push_back(mkp(32'h8000_03B7, 32'h8000_0000, 32'd20));         // lui x7,0x80000
        vecs.push_back(mkp(32'h4043_D413, 32'hF800_0000, 32'd24));         // srai x8,x7,4
        vecs.push_back(mkp(32'h4070_84B3, 32'h8000_0002, 32'd28));         // sub x9,x1,x7
        vecs.push_back(mkp(32'h0070_B533, 32'd1, 32'd32));                 // sltu x10,x1,x7
        vecs.push_back(mkp(32'h0070_A5B3, 32'd0, 32'd36));                 // slt x11,x1,x7
        vecs.push_back(mkp(32'h0000_1617, 32'h0000_1024, 32'd40));         // auipc x12,1
        vecs.push_back(mk (32'h0070_1323, 0, 32'd6, 1, 32'h8000_0000, 2'b10, 3'b010, 0, 32'd44)); // sh x7,6(x0)
        vecs.push_back(mk (32'hFE10_8FA3, 0, 32'd1, 1, 32'd2, 2'b01, 3'b010, 0, 32'd48));         // sb x1,-1(x1)
        vecs.push_back(mk (32'h0000_D683, 32'h0000_BEEF, 32'd2, 0, 0, 2'b00, 3'b101, 1, 32'd52)); // lhu x13,0(x1)
        vecs.push_back(mkp(32'h0006_8013, 32'h0000_BEEF, 32'd56));         // probe x13
        vecs.push_back(mkp(32'h0000_00F3, 32'd0, 32'd60));                 // SYSTEM with rd=x1 -> NOP
        vecs.push_back(mkp(32'h0000_8013, 32'd2, 32'd64));                 // probe x1 unchanged
        vecs.push_back(mkp(32'h0013_C463, 32'h7FFF_FFFE, 32'd72));         // blt x7,x1,+8 taken
        vecs.push_back(mkp(32'hFA13_FCE3, 32'h7FFF_FFFE, 32'd0));          // bgeu x7,x1,-72 taken

        reset = 1'b1; instr = 32'd0; data_in = 32'd0;
        #1;
        chk("reset PC", PC, 32'd0);
        chk("reset MemWrite", {30'd0, MemWrite}, 32'd0);
        @(posedge clk); #1;
        chk("reset PC held", PC, 32'd0);
        @(negedge clk) reset = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            instr = vecs[i].instr; data_in = vecs[i].din;
            #1;
            chk($sformatf("v%0d ALU_result", i), ALU_result, vecs[i].alu);
            chk($sformatf("v%0d ctrl", i), {26'd0, MemWrite, SizeLoad, ResultSrc},
                {26'd0, vecs[i].mw, vecs[i].sl, vecs[i].rs});
            if (vecs[i].chk_dout) chk($sformatf("v%0d data_out", i), data_out, vecs[i].dout);
            @(posedge clk); #1;
            chk($sformatf("v%0d PC", i), PC, vecs[i].pc_nxt);
        end

        // async reset mid-cycle: PC at 4, reset asserted away from any clk edge
        @(negedge clk); instr = 32'h0000_0013;
        @(posedge clk); #1;
        chk("pre-reset PC", PC, 32'd4);
        #2 reset = 1'b1;
        #1 chk("async reset PC", PC, 32'd0);
        // a write attempted under reset must be dropped
        instr = 32'h0070_0093;                                  // addi x1,x0,7
        @(posedge clk); #1;
        chk("PC during reset", PC, 32'd0);
        @(negedge clk) reset = 1'b0;
        instr = 32'h0000_8013;                                  // probe x1
        #1;
`ifdef CPU_USM_RF_CLEAR_EN
        x1_exp = 32'd0;
`else
        x1_exp = 32'd2;
`endif
        chk("x1 after reset", ALU_result, x1_exp);
        @(posedge clk); #1;
        chk("PC after reset release", PC, 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
